read_port_arbiter: RTL and testbench

READ_PORT_ARBITER -- requirements
Module: read_port_arbiter

---
 rtl/read_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_read_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/read_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : read_port_arbiter
//  Description : Shares one recursive-mux read port between NUM_REQ
//                requesters. A winner is picked in IDLE, its select is
//                registered onto mux_sel and held for SETTLE_CYCLES cycles
//                so the mux tree can settle, then mux_out is captured into
//                rd_data alongside a one-cycle ack pulse to the owner.
//
//  Parameters  : NUM_REQ       - requesters (power of two, 2..8)
//                WIDTH         - mux data inputs (power of two)
//                SETTLE_CYCLES - cycles mux_sel is held before capture (1..15)
//
//  Ports       : clk      in   sole clock, rising edge
//                reset_n  in   asynchronous active-low reset
//                req      in   per-requester request, held until ack
//                req_sel  in   flattened selects, requester i at [i*SEL_W +: SEL_W]
//                mux_sel  out  registered select to the shared mux
//                mux_out  in   shared mux output
//                grant    out  registered one-hot owner, zero when idle
//                ack      out  one-cycle one-hot completion pulse
//                rd_data  out  captured mux_out, valid while ack is high
//
//  Options     : READ_ARB_FIXED_PRIO_EN - when defined, lowest index wins
//                (fixed priority); otherwise round-robin.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module read_port_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*$clog2(WIDTH)-1:0]    req_sel,
    output logic [$clog2(WIDTH)-1:0]            mux_sel,
    input  logic                                mux_out,
    output logic [NUM_REQ-1:0]                  grant,
    output logic [NUM_REQ-1:0]                  ack,
    output logic                                rd_data
);

    localparam int         SEL_W        = $clog2(WIDTH);
    localparam int         c_IDX_W      = $clog2(NUM_REQ);
    localparam logic [3:0] c_SETTLE_LD  = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_cnt;
    logic [NUM_REQ-1:0]     r_grant;
    logic [NUM_REQ-1:0]     r_ack;
    logic [SEL_W-1:0]       r_mux_sel;
    logic                   r_rd_data;

    logic [c_IDX_W-1:0]     w_win_idx;
    logic [NUM_REQ-1:0]     w_win_onehot;
    logic                   w_any_req;

    assign w_any_req = |req;

`ifdef READ_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest requesting index is the last one written.
    always_comb begin
        w_win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_win_idx = c_IDX_W'(i);
            end
        end
    end
`else
    logic [c_IDX_W-1:0]     r_ptr;
    logic [c_IDX_W-1:0]     r_grant_idx;
    logic [c_IDX_W-1:0]     w_cand;
    logic                   w_hit;

    // Search begins one past the last owner; the index arithmetic wraps
    // naturally because NUM_REQ is a power of two, and the final step
    // (offset NUM_REQ) lands back on the last owner itself.
    always_comb begin
        w_win_idx = '0;
        w_cand    = '0;
        w_hit     = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = r_ptr + c_IDX_W'(i);
            if (!w_hit && req[w_cand]) begin
                w_hit     = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end

    // Pointer moves only when a transaction is committed (entry to ACK),
    // so an aborted transaction does not rotate priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= c_IDX_W'(NUM_REQ - 1);
            r_grant_idx <= '0;
        end else begin
            if (r_state == ST_IDLE && w_any_req) begin
                r_grant_idx <= w_win_idx;
            end
            if (r_state == ST_SETTLE && r_cnt == 4'd0) begin
                r_ptr <= r_grant_idx;
            end
        end
    end
`endif

    assign w_win_onehot = NUM_REQ'(1) << w_win_idx;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_req)      w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (r_cnt == 4'd0)  w_state_nxt = ST_ACK;
            ST_ACK:                        w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered datapath: grant, select, settle counter, capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant   <= '0;
            r_ack     <= '0;
            r_mux_sel <= '0;
            r_rd_data <= 1'b0;
            r_cnt     <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant   <= w_win_onehot;
                        r_mux_sel <= req_sel[w_win_idx*SEL_W +: SEL_W];
                        r_cnt     <= c_SETTLE_LD;
                    end else begin
                        r_grant   <= '0;
                    end
                end
                ST_SETTLE: begin
                    // req and req_sel are ignored here: the owner may drop
                    // its request and still receive its ack.
                    if (r_cnt == 4'd0) begin
                        r_rd_data <= mux_out;
                        r_ack     <= r_grant;
                    end else begin
                        r_cnt     <= r_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    r_ack   <= '0;
                    r_grant <= '0;
                end
                default: begin
                    r_ack   <= '0;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign mux_sel = r_mux_sel;
    assign grant   = r_grant;
    assign ack     = r_ack;
    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_read_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_read_port_arbiter
//  Description : Directed self-checking bench for read_port_arbiter. One
//                instance uses the default configuration, a second uses
//                SETTLE_CYCLES=1. The shared mux is a behavioural index
//                into a test pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_read_port_arbiter;

    logic        clk;
    logic        reset_n;

    // default instance: NUM_REQ=4, WIDTH=32, SETTLE_CYCLES=2
    logic [3:0]  req;
    logic [19:0] req_sel;
    logic [4:0]  mux_sel;
    logic        mux_out;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        rd_data;
    logic [31:0] mux_in;

    // short-settle instance: SETTLE_CYCLES=1
    logic [3:0]  req1;
    logic [19:0] req_sel1;
    logic [4:0]  mux_sel1;
    logic        mux_out1;
    logic [3:0]  grant1;
    logic [3:0]  ack1;
    logic        rd_data1;

    int          n_checks;
    int          n_errors;
    int          cyc;

    assign mux_out  = mux_in[mux_sel];
    assign mux_out1 = mux_in[mux_sel1];

    read_port_arbiter #(
        .NUM_REQ       (4),
        .WIDTH         (32),
        .SETTLE_CYCLES (2)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .req_sel (req_sel),
        .mux_sel (mux_sel),
        .mux_out (mux_out),
        .grant   (grant),
        .ack     (ack),
        .rd_data (rd_data)
    );

    read_port_arbiter #(
        .NUM_REQ       (4),
        .WIDTH         (32),
        .SETTLE_CYCLES (1)
    ) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req1),
        .req_sel (req_sel1),
        .mux_sel (mux_sel1),
        .mux_out (mux_out1),
        .grant   (grant1),
        .ack     (ack1),
        .rd_data (rd_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_rd;
        logic [3:0] exp_g;
        int         last_ack;

        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        reset_n  = 1'b0;
        req      = 4'b0000;
        req_sel  = '0;
        req1     = 4'b0000;
        req_sel1 = '0;
        mux_in   = 32'h0000_0020;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_val("rst_grant",   32'(grant),   32'h0);
        check_val("rst_ack",     32'(ack),     32'h0);
        check_val("rst_mux_sel", 32'(mux_sel), 32'h0);
        check_val("rst_rd_data", 32'(rd_data), 32'h0);
        reset_n = 1'b1;

        // ---------------- single read, requester 0, select 5 ----------------
        req_sel[4:0] = 5'd5;
        req          = 4'b0001;
        tick();
        check_val("t1_grant",   32'(grant),   32'h1);
        check_val("t1_mux_sel", 32'(mux_sel), 32'd5);
        check_val("t1_ack0",    32'(ack),     32'h0);
        tick();
        check_val("t1_ack1",    32'(ack),     32'h0);
        tick();
        check_val("t1_ack",     32'(ack),     32'h1);
        check_val("t1_rd",      32'(rd_data), 32'h1);
        req = 4'b0000;
        tick();
        check_val("t1_idle_g",  32'(grant),   32'h0);
        check_val("t1_idle_a",  32'(ack),     32'h0);

        // restart arbitration from the reset pointer
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;

        // ---------------- all four requesting: round-robin order ----------------
        // selects 2,9,16,23; pattern bits 2,9,23 set, bit 16 clear
        mux_in  = 32'h0080_0204;
        req_sel = {5'd23, 5'd16, 5'd9, 5'd2};
        exp_rd  = 4'b1011;
        req     = 4'b1111;
        last_ack = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val($sformatf("rr_grant%0d", k), 32'(grant), 32'(4'b0001 << (k % 4)));
            tick();
            tick();
            check_val($sformatf("rr_ack%0d", k), 32'(ack), 32'(4'b0001 << (k % 4)));
            check_val($sformatf("rr_rd%0d", k), 32'(rd_data), 32'(exp_rd[k % 4]));
            if (k > 0) begin
                check_val($sformatf("rr_space%0d", k), 32'(cyc - last_ack), 32'd4);
            end
            last_ack = cyc;
            tick();
            check_val($sformatf("rr_idle%0d", k), 32'(grant), 32'h0);
        end
        req = 4'b0000;

        // ---------------- requester 2 drops request during SETTLE ----------------
        req = 4'b0100;
        tick();
        check_val("drop_grant", 32'(grant), 32'h4);
        req = 4'b0000;
        tick();
        tick();
        check_val("drop_ack",   32'(ack),   32'h4);
        tick();
        check_val("drop_idle",  32'(grant), 32'h0);
        tick();
        check_val("drop_nogr",  32'(grant), 32'h0);

        // ---------------- reset in the middle of SETTLE ----------------
        req_sel[4:0] = 5'd6;
        req = 4'b0001;
        tick();
        check_val("ar_grant",   32'(grant),   32'h1);
        check_val("ar_sel",     32'(mux_sel), 32'd6);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("ar_grant0",  32'(grant),   32'h0);
        check_val("ar_ack0",    32'(ack),     32'h0);
        check_val("ar_sel0",    32'(mux_sel), 32'h0);
        tick();
        tick();
        check_val("ar_noack",   32'(ack),     32'h0);
        req     = 4'b1000;
        reset_n = 1'b1;
        tick();
        check_val("ar_grant3",  32'(grant),   32'h8);
        tick();
        tick();
        check_val("ar_ack3",    32'(ack),     32'h8);
        req = 4'b0000;
        tick();

        // ---------------- SETTLE_CYCLES=1, select changes after grant ----------------
        mux_in         = 32'h0000_0008;   // in[3]=1, in[7]=0
        req_sel1[4:0]  = 5'd3;
        req1           = 4'b0001;
        tick();
        check_val("s1_grant",   32'(grant1),   32'h1);
        check_val("s1_sel",     32'(mux_sel1), 32'd3);
        req_sel1[4:0]  = 5'd7;
        #1;
        check_val("s1_sel_hold", 32'(mux_sel1), 32'd3);
        tick();
        check_val("s1_ack",     32'(ack1),     32'h1);
        check_val("s1_sel_ack", 32'(mux_sel1), 32'd3);
        check_val("s1_rd",      32'(rd_data1), 32'h1);
        req1 = 4'b0000;
        tick();
        check_val("s1_idle",    32'(grant1),   32'h0);

        // ---------------- requesters 1 and 2 held ----------------
        // pointer sits at 3 after the last default-instance transaction
        req = 4'b0110;
        for (int k = 0; k < 4; k++) begin
`ifdef READ_ARB_FIXED_PRIO_EN
            exp_g = 4'b0010;
`else
            exp_g = (k % 2 == 0) ? 4'b0010 : 4'b0100;
`endif
            tick();
            check_val($sformatf("p12_grant%0d", k), 32'(grant), 32'(exp_g));
            tick();
            tick();
            check_val($sformatf("p12_ack%0d", k), 32'(ack), 32'(exp_g));
            tick();
        end
        req = 4'b0000;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
